matrix_stream_loader: RTL and testbench
=======================================

// Module: matrix_stream_loader
// PURPOSE
//  Write-side front end for the matrix register file. Accepts a serial
//  valid/ready stream of DW-bit elements and fills one RW x CW matrix.
//  Each accepted element becomes a one-hot per-element write strobe plus
//  broadcast write data, which feed the regfile's wren/wr_data arrays directly.
//  Row-major or column-major (transpose) fill order is selected per load.
// PARAMETERS
//  DW  16  element data width (bits)
//  RW  4   matrix rows, >=1
//  CW  4   matrix columns, >=1
// PORTS
//  clk        in   1               sole clock, rising edge
//  rst        in   1               synchronous reset, active-high
//  start      in   1               begin a matrix load (sampled in IDLE only)
//  transpose  in   1               fill order; sampled with start (0=row-major, 1=column-major)
//  in_valid   in   1               stream element valid
//  in_data    in   DW              stream element
//  in_ready   out  1               loader accepts element this cycle
//  wren       out  [0:RW-1][0:CW-1]       one-hot per-element write enable
//  wr_data    out  [0:RW-1][0:CW-1][DW]   write data, same value to all elements
//  busy       out  1               load in progress (state != IDLE)
//  done       out  1               one-cycle pulse, matrix fully written
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): state=IDLE, row/col counters=0, all wren=0,
//    all wr_data=0, in_ready=0, busy=0, done=0. Mid-load reset abandons the load
//    with no further strobes; elements already strobed stay in the regfile.
//  - FSM: IDLE -start-> LOAD -last accept-> FLUSH -> DONE -> IDLE.
//    IDLE: in_ready=0; start=1 latches transpose, clears counters, enters LOAD.
//    LOAD: in_ready=1 (combinational from state only, not from in_valid).
//    FLUSH: in_ready=0; last element's wren is high this cycle.
//    DONE: done=1 for exactly one cycle; next cycle IDLE. start in DONE is ignored.
//  - start in LOAD/FLUSH/DONE is ignored. transpose changes mid-load are ignored.
//  - Accept = in_valid & in_ready at a clk edge. On accept at edge t, from t
//    until the next edge: wren[r][c]=1 only at the current (r,c), and every
//    wr_data element = in_data. Latency is 1 cycle, registered outputs.
//    wren returns to all-0 on any cycle without an accept; wr_data holds its last value.
//  - Order, row-major: c increments; at c=CW-1, c<=0 and r increments.
//    Column-major: r increments; at r=RW-1, r<=0 and c increments.
//  - The last element is (RW-1,CW-1) in both orders. Its accept moves LOAD->FLUSH;
//    counters wrap to (0,0). Exactly RW*CW strobes per load, none duplicated.
//  - Stalls: in_valid=0 in LOAD holds the counters and produces no strobe;
//    there is no timeout.
//  - Counter widths are $clog2 of RW/CW, minimum 1 bit. RW=1 or CW=1 is legal;
//    RW=CW=1 means a single element followed by FLUSH.
//  - busy=1 in LOAD, FLUSH and DONE. At most one wren bit is set in any cycle.
// TESTING
//  1. Reset: rst=1 for 2 cycles -> all outputs 0, in_ready=0, busy=0.
//  2. Row-major, DW=16, 4x4: start, transpose=0, stream 0x0000..0x000F with
//     in_valid always 1 -> wren[0][0]..[3][3] in order, one per cycle; element k
//     strobed with data k; done pulses 2 cycles after the 16th accept; the
//     regfile then holds M[r][c]=4r+c.
//  3. Column-major: same stream with transpose=1 -> strobe k at
//     (r=k%4, c=k/4); regfile then holds M[r][c]=r+4c.
//  4. Back-pressure: in_valid toggles 1,0,0,1,... -> no wren on idle cycles,
//     order unchanged, exactly 16 strobes, one done pulse.
//  5. Ignored inputs: start pulsed mid-LOAD and in DONE; transpose flipped
//     mid-load -> no restart, order unchanged; in_valid=1 while IDLE ->
//     in_ready=0 and no wren.
//  6. Reset mid-load after 7 accepts -> next cycle IDLE with all wren 0; a new
//     start then strobes (0,0) first; no done from the aborted load.

Source files
------------

// File: rtl/matrix_stream_loader_if.sv
// Stream-in / regfile-write bundle for matrix_stream_loader.
// master = stream producer and regfile side, slave = the loader itself.
interface matrix_stream_loader_if #(
    parameter int DW = 16,
    parameter int RW = 4,
    parameter int CW = 4
);
    logic                               start;
    logic                               transpose;
    logic                               in_valid;
    logic [DW-1:0]                      in_data;
    logic                               in_ready;
    logic [0:RW-1][0:CW-1]              wren;
    logic [0:RW-1][0:CW-1][DW-1:0]      wr_data;
    logic                               busy;
    logic                               done;

    modport master (
        output start, transpose, in_valid, in_data,
        input  in_ready, wren, wr_data, busy, done
    );

    modport slave (
        input  start, transpose, in_valid, in_data,
        output in_ready, wren, wr_data, busy, done
    );
endinterface

// File: rtl/matrix_stream_loader.sv
// Write-side front end of the matrix register file: turns a serial
// valid/ready element stream into one-hot per-element write strobes with
// broadcast data, filling an RW x CW matrix in row- or column-major order.
module matrix_stream_loader #(
    parameter int DW = 16,
    parameter int RW = 4,
    parameter int CW = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    matrix_stream_loader_if.slave  bus
);
    localparam int RBW = (RW > 1) ? $clog2(RW) : 1;
    localparam int CBW = (CW > 1) ? $clog2(CW) : 1;

    localparam logic [RBW-1:0] ROW_LAST = RBW'(RW - 1);
    localparam logic [CBW-1:0] COL_LAST = CBW'(CW - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]     state;
    logic [RBW-1:0] row;
    logic [CBW-1:0] col;
    logic           col_major;
    logic           accept;
    logic           last;

    // Ready depends on state only, so the producer never sees a combinational
    // path from its own valid back to ready.
    assign bus.in_ready = (state == LOAD);
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);

    assign accept = bus.in_valid && (state == LOAD);
    assign last   = (row == ROW_LAST) && (col == COL_LAST);

    // Load sequencing: state, fill-order latch and the (row, col) write pointer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register here samples the pre-edge values of its neighbours.
        if (rst) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            col_major <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        col_major <= bus.transpose;
                        row       <= '0;
                        col       <= '0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (last) begin
                            row   <= '0;
                            col   <= '0;
                            state <= FLUSH;
                        end else if (col_major) begin
                            if (row == ROW_LAST) begin
                                row <= '0;
                                col <= col + 1'b1;
                            end else begin
                                row <= row + 1'b1;
                            end
                        end else begin
                            if (col == COL_LAST) begin
                                col <= '0;
                                row <= row + 1'b1;
                            end else begin
                                col <= col + 1'b1;
                            end
                        end
                    end
                end
                FLUSH:   state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Registered write port: one strobe per accepted element, data broadcast.
    always_ff @(posedge clk) begin
        // NOTE: wr_data is a small output register bank, not a memory array,
        // so it is cleared on reset along with the strobes.
        if (rst) begin
            bus.wren    <= '0;
            bus.wr_data <= '0;
        end else begin
            bus.wren <= '0;
            if (accept) begin
                for (int r = 0; r < RW; r++) begin
                    for (int c = 0; c < CW; c++) begin
                        bus.wren[r][c]    <= (row == RBW'(r)) && (col == CBW'(c));
                        bus.wr_data[r][c] <= bus.in_data;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_matrix_stream_loader.sv
// Directed self-checking bench for matrix_stream_loader (4x4, 16-bit).
// Expected strobes are queued as elements are driven and checked as the
// write strobes appear; a bench-side regfile collects the written matrix.
module tb_matrix_stream_loader;
    localparam int DW = 16;
    localparam int RW = 4;
    localparam int CW = 4;

    typedef struct {
        int            r;
        int            c;
        logic [DW-1:0] d;
    } exp_t;

    logic clk;
    logic rst;

    matrix_stream_loader_if #(.DW(DW), .RW(RW), .CW(CW)) bus ();

    matrix_stream_loader #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t          sb[$];
    logic [DW-1:0] model_rf [RW][CW];
    int            n_assert = 0;
    int            n_fail   = 0;
    int            n_strobe = 0;
    int            n_done   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: compares each write strobe with the head of the scoreboard.
    always @(negedge clk) begin
        int   hr;
        int   hc;
        exp_t e;
        if ((|bus.wren) === 1'b1) begin
            n_strobe++;
            hr = 0;
            hc = 0;
            check("wren_onehot", 32'($countones(bus.wren)), 32'd1);
            for (int r = RW - 1; r >= 0; r--)
                for (int c = CW - 1; c >= 0; c--)
                    if (bus.wren[r][c] === 1'b1) begin
                        hr = r;
                        hc = c;
                    end
            model_rf[hr][hc] = bus.wr_data[hr][hc];
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("strobe_row", 32'(hr), 32'(e.r));
                check("strobe_col", 32'(hc), 32'(e.c));
                check("strobe_data", 32'(bus.wr_data[hr][hc]), 32'(e.d));
                check("bcast_data_00", 32'(bus.wr_data[0][0]), 32'(e.d));
                check("bcast_data_33", 32'(bus.wr_data[RW-1][CW-1]), 32'(e.d));
            end
        end
        if (bus.done === 1'b1) n_done++;
    end

    task automatic start_load(input logic tr);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.transpose = tr;
        @(negedge clk);
        bus.start = 1'b0;
        check("load_busy", 32'(bus.busy), 32'd1);
        check("load_ready", 32'(bus.in_ready), 32'd1);
    endtask

    // Presents element k after 'gaps' idle cycles; queues where it must land.
    task automatic drive_elem(input int k, input logic tr, input logic [DW-1:0] data, input int gaps);
        exp_t e;
        repeat (gaps) begin
            bus.in_valid = 1'b0;
            bus.in_data  = ~data;
            @(negedge clk);
        end
        e.r = tr ? (k % RW) : (k / CW);
        e.c = tr ? (k / RW) : (k % CW);
        e.d = data;
        check("elem_ready", 32'(bus.in_ready), 32'd1);
        sb.push_back(e);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Tail of a full load: FLUSH, one-cycle done, back to IDLE, then totals.
    task automatic finish_load(input logic tr, input logic [DW-1:0] base,
                               input int strobe0, input int done0, input logic start_in_done);
        check("flush_ready", 32'(bus.in_ready), 32'd0);
        check("flush_busy", 32'(bus.busy), 32'd1);
        check("flush_done", 32'(bus.done), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(bus.done), 32'd1);
        check("done_busy", 32'(bus.busy), 32'd1);
        bus.start = start_in_done;
        @(negedge clk);
        bus.start = 1'b0;
        check("idle_done", 32'(bus.done), 32'd0);
        check("idle_busy", 32'(bus.busy), 32'd0);
        check("idle_ready", 32'(bus.in_ready), 32'd0);
        check("strobe_total", 32'(n_strobe - strobe0), 32'(RW * CW));
        check("done_total", 32'(n_done - done0), 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
        for (int r = 0; r < RW; r++)
            for (int c = 0; c < CW; c++)
                check($sformatf("rf_%0d_%0d", r, c), 32'(model_rf[r][c]),
                      32'(base + (tr ? DW'(r + RW * c) : DW'(r * CW + c))));
    endtask

    initial begin
        int s0;
        int d0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.transpose = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        for (int r = 0; r < RW; r++)
            for (int c = 0; c < CW; c++)
                model_rf[r][c] = 'x;

        // 1. Reset state
        repeat (2) @(negedge clk);
        check("rst_wren", 32'(bus.wren), 32'd0);
        check("rst_wr_data_zero", 32'(bus.wr_data == '0), 32'd1);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;

        // 2. Row-major, continuous valid
        s0 = n_strobe; d0 = n_done;
        start_load(1'b0);
        for (int k = 0; k < RW * CW; k++) drive_elem(k, 1'b0, DW'(k), 0);
        finish_load(1'b0, '0, s0, d0, 1'b0);

        // 3. Column-major, continuous valid
        s0 = n_strobe; d0 = n_done;
        start_load(1'b1);
        for (int k = 0; k < RW * CW; k++) drive_elem(k, 1'b1, DW'(k), 0);
        finish_load(1'b1, '0, s0, d0, 1'b0);

        // 4. Back-pressure: valid pattern 1,0,0,1,0,0,...
        s0 = n_strobe; d0 = n_done;
        start_load(1'b0);
        for (int k = 0; k < RW * CW; k++)
            drive_elem(k, 1'b0, 16'hA500 + DW'(k), (k == 0) ? 0 : 2);
        finish_load(1'b0, 16'hA500, s0, d0, 1'b0);

        // 5. Ignored start/transpose mid-load and start in DONE
        s0 = n_strobe; d0 = n_done;
        start_load(1'b0);
        for (int k = 0; k < RW * CW; k++) begin
            if (k == 5) begin
                bus.start     = 1'b1;
                bus.transpose = 1'b1;
            end
            drive_elem(k, 1'b0, 16'h5A00 + DW'(k), (k % 3 == 1) ? 1 : 0);
            bus.start = 1'b0;
        end
        finish_load(1'b0, 16'h5A00, s0, d0, 1'b1);
        // in_valid while IDLE: no ready, no strobe
        s0 = n_strobe;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hDEAD;
        @(negedge clk);
        check("idle_valid_ready", 32'(bus.in_ready), 32'd0);
        check("idle_valid_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("idle_valid_nostrobe", 32'(n_strobe - s0), 32'd0);

        // 6. Reset after 7 accepts, then a fresh load from (0,0)
        d0 = n_done;
        start_load(1'b0);
        for (int k = 0; k < 7; k++) drive_elem(k, 1'b0, 16'h7700 + DW'(k), 0);
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        @(negedge clk);
        check("abort_wren", 32'(bus.wren), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_ready", 32'(bus.in_ready), 32'd0);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        check("abort_sb_empty", 32'(sb.size()), 32'd0);
        s0 = n_strobe; d0 = n_done;
        start_load(1'b0);
        for (int k = 0; k < RW * CW; k++) drive_elem(k, 1'b0, 16'h3300 + DW'(k), 0);
        finish_load(1'b0, 16'h3300, s0, d0, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
